if_fetch_unit: RTL and testbench
================================

# if_fetch_unit

Instruction-fetch stage for the MIPS pipeline, acting as the initiator toward the combinational instruction ROM. Each cycle it drives a word address to the ROM and captures the returned instruction with its PC into a 2-entry skid buffer. It presents instructions to the IF/ID register through a valid/ready handshake and accepts PC redirects from the branch/jump logic.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; bits [1:0] must be 0.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `imem_addr`  out  32  ROM address; combinational copy of the PC register.
- `imem_data`  in  32  ROM read data, valid in the same cycle as `imem_addr`.
- `redirect_valid`  in  1  one-cycle request to load a new PC.
- `redirect_pc`  in  32  target PC; bits [1:0] ignored and forced to 0.
- `out_valid`  out  1  buffer head holds an instruction.
- `out_ready`  in  1  IF/ID accepts the head this cycle.
- `out_instr`  out  32  instruction at the buffer head.
- `out_pc`  out  32  PC of `out_instr`.
- `halted`  out  1  fetch stopped on an illegal word; see Configuration.

## Operation
- State: `pc` (32 b), 2-entry buffer of {pc, instr}, read/write pointers, `count` (0..2), FSM {RUN, HALT}.
- pop = `out_valid & out_ready`.
- push (RUN only) = `!redirect_valid & (count < 2 | pop)`. On push: write {pc, imem_data}, then pc <= pc + 4, wrapping from 32'hFFFF_FFFC to 0 (modulo 2^32).
- No push: pc holds.
- Redirect has priority over push and pop:
  - Buffer is emptied (count <= 0, pointers reset).
  - pc <= {redirect_pc[31:2], 2'b00}.
  - FSM <= RUN.
  - A pop in the redirect cycle is still a completed transfer. Squashing that instruction downstream belongs to the hazard unit.
- Simultaneous push and pop: count is unchanged.
- `out_instr` and `out_pc` come from buffer storage, not from `imem_data`. With `count == 0` they hold the last written entry (don't-care).
- Reset values:
  - pc = RESET_PC, so `imem_addr` = RESET_PC.
  - count = 0, `out_valid` = 0, `out_instr` = 0, `out_pc` = 0.
  - `halted` = 0, FSM = RUN, both buffer entries cleared to 0.
- Reset mid-operation: all buffered instructions are discarded and fetch restarts at RESET_PC on the first edge after `rst` falls.

## Timing
- Fetch-to-output latency is 1 cycle: a word addressed in cycle N is visible on `out_*` with `out_valid` = 1 in cycle N+1.
- Throughput is 1 instruction/cycle while `out_ready` = 1. The buffer stays at count 1 and no bubbles appear.
- `out_ready` low: the buffer fills to 2 within 2 cycles, then fetch stops and pc holds. When `out_ready` returns high, the next pop and push happen in the same cycle.
- Redirect sampled at edge E:
  - `out_valid` = 0 in the cycle after E.
  - `imem_addr` = target in the cycle after E.
  - The target instruction appears on `out_*` after edge E+1, giving a 2-cycle redirect penalty.
- `redirect_valid` held high for multiple cycles: each cycle re-applies the redirect and no fetch occurs.

## Configuration
- `FETCH_HALT_ON_ILLEGAL_EN` defined:
  - In RUN, a push-eligible cycle with `imem_data` == 32'hFFFF_FFFF (the ROM's unmapped word) does not push and does not advance pc.
  - FSM -> HALT and `halted` = 1 from the next cycle.
  - In HALT, no fetches occur. Buffered entries still drain normally.
  - HALT is left only by redirect (-> RUN at target, `halted` = 0 next cycle) or by `rst`.
- Macro undefined:
  - 32'hFFFF_FFFF is pushed like any other word.
  - FSM is fixed in RUN and `halted` is tied to 0.

## Test plan
- Reset and stream: RESET_PC = 0, ROM model returns `addr ^ 32'hA5A5_0000`, `out_ready` = 1. Expect `out_valid` = 1 one cycle after reset release, with `out_pc` = 0, 4, 8, … and `out_instr` = 32'hA5A5_0000, 32'hA5A5_0004, … on consecutive cycles, no gaps.
- Backpressure: drop `out_ready` for 5 cycles. Expect count to saturate at 2 and `imem_addr` to freeze. After release, the PC sequence continues with no duplicate and no skip.
- Redirect with full buffer: count = 2, `redirect_pc` = 32'h0000_0043. Expect `out_valid` = 0 next cycle, then `out_pc` = 32'h0000_0040. Older entries never appear.
- Wrap: redirect to 32'hFFFF_FFFC. Expect `out_pc` = 32'hFFFF_FFFC followed by 32'h0000_0000.
- Illegal word with macro defined: ROM returns 32'hFFFF_FFFF at 32'h44. Expect 32'h40 delivered, 32'h44 never pushed, `halted` = 1, and `imem_addr` stuck at 32'h44. A redirect to 32'h08 clears `halted` and resumes fetching. Without the macro, 32'hFFFF_FFFF is delivered with `out_pc` = 32'h44.
- Reset mid-stream: assert `rst` while count = 2. Expect `out_valid` = 0, `out_pc` = 0 and `imem_addr` = RESET_PC in the next cycle.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: drives the ROM address, captures {pc, instr} into a 2-entry skid buffer.
// Optional halt on the unmapped ROM word is enabled by defining FETCH_HALT_ON_ILLEGAL_EN.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        halted
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] buf_pc_q    [2];
    logic [31:0] buf_pc_d    [2];
    logic [31:0] buf_instr_q [2];
    logic [31:0] buf_instr_d [2];
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  count_q, count_d;

    logic        pop;
    logic        fetch_ok;
    logic        illegal;
    logic        push;

`ifdef FETCH_HALT_ON_ILLEGAL_EN
    assign illegal = (imem_data == 32'hFFFF_FFFF);
`else
    assign illegal = 1'b0;
`endif

    // A full buffer may still accept a word when the head leaves in the same cycle.
    assign pop      = (count_q != 2'd0) & out_ready;
    assign fetch_ok = (state_q == RUN) & ~redirect_valid & ((count_q < 2'd2) | pop);
    assign push     = fetch_ok & ~illegal;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        if (redirect_valid) begin
            state_d = RUN;
        end else if (fetch_ok & illegal) begin
            state_d = HALT;
        end
    end

    // FSM: outputs
    always_comb begin
        halted = (state_q == HALT);
    end

    always_comb begin
        pc_d        = pc_q;
        buf_pc_d    = buf_pc_q;
        buf_instr_d = buf_instr_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (redirect_valid) begin
            pc_d     = redirect_pc & 32'hFFFF_FFFC;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push) begin
                buf_pc_d[wr_ptr_q]    = pc_q;
                buf_instr_d[wr_ptr_q] = imem_data;
                wr_ptr_d              = ~wr_ptr_q;
                pc_d                  = pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            pc_q     <= RESET_PC;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            // NOTE: the two buffer entries are reset because out_pc/out_instr must read 0 after reset.
            for (int i = 0; i < 2; i++) begin
                buf_pc_q[i]    <= 32'd0;
                buf_instr_q[i] <= 32'd0;
            end
        end else begin
            pc_q        <= pc_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            buf_pc_q    <= buf_pc_d;
            buf_instr_q <= buf_instr_d;
        end
    end

    assign imem_addr = pc_q;
    assign out_valid = (count_q != 2'd0);
    assign out_pc    = buf_pc_q[rd_ptr_q];
    assign out_instr = buf_instr_q[rd_ptr_q];

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: ROM model plus a queue-based reference of the fetch stream.
// Honours FETCH_HALT_ON_ILLEGAL_EN when the same macro is defined for the bench.
module tb_if_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        halted;

    logic        bad_en;

    if_fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .halted         (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] addr, input logic bad);
        if (bad && addr == 32'h0000_0044) return 32'hFFFF_FFFF;
        return addr ^ 32'hA5A5_0000;
    endfunction

    assign imem_data = rom(imem_addr, bad_en);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        m_q[$];
    logic [31:0] m_pc;
    logic        m_halt;

`ifdef FETCH_HALT_ON_ILLEGAL_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    int n_tests;
    int n_fail;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pc   = RESET_PC;
        m_halt = 1'b0;
    endtask

    // One clock cycle: drive inputs, compare outputs against the model, then advance both.
    task automatic cycle(input logic rv, input logic [31:0] rpc, input logic rdy);
        logic        do_pop;
        logic [31:0] w;
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
        #1;
        check("out_valid", {31'd0, out_valid}, {31'd0, m_q.size() != 0});
        if (m_q.size() != 0) begin
            check("out_pc", out_pc, m_q[0].pc);
            check("out_instr", out_instr, m_q[0].instr);
        end
        check("imem_addr", imem_addr, m_pc);
        check("halted", {31'd0, halted}, {31'd0, m_halt});

        do_pop = (m_q.size() != 0) && rdy;
        if (rv) begin
            m_q.delete();
            m_pc   = {rpc[31:2], 2'b00};
            m_halt = 1'b0;
        end else begin
            if (do_pop) void'(m_q.pop_front());
            if (!m_halt && m_q.size() < 2) begin
                w = rom(m_pc, bad_en);
                if (HALT_EN && w == 32'hFFFF_FFFF) begin
                    m_halt = 1'b1;
                end else begin
                    m_q.push_back('{pc: m_pc, instr: w});
                    m_pc = m_pc + 32'd4;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        bad_en         = 1'b0;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        out_ready      = 1'b0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_pc", out_pc, 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_imem_addr", imem_addr, RESET_PC);
        check("rst_halted", {31'd0, halted}, 32'd0);
        rst = 1'b0;

        // Streaming with out_ready held high
        for (int i = 0; i < 12; i++) cycle(1'b0, 32'd0, 1'b1);

        // Backpressure for 5 cycles, then release
        for (int i = 0; i < 5; i++) cycle(1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 32'd0, 1'b1);

        // Redirect while the buffer is full
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'd0, 1'b0);
        cycle(1'b1, 32'h0000_0043, 1'b0);
        check("redir_empty", {31'd0, out_valid}, 32'd0);
        check("redir_addr", imem_addr, 32'h0000_0040);
        for (int i = 0; i < 6; i++) cycle(1'b0, 32'd0, 1'b1);

        // PC wrap
        cycle(1'b1, 32'hFFFF_FFFC, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b0, 32'd0, 1'b1);

        // Unmapped word at 0x44, then redirect to 0x08
        bad_en = 1'b1;
        cycle(1'b1, 32'h0000_0030, 1'b1);
        for (int i = 0; i < 10; i++) cycle(1'b0, 32'd0, 1'b1);
        cycle(1'b1, 32'h0000_0008, 1'b1);
        for (int i = 0; i < 6; i++) cycle(1'b0, 32'd0, 1'b1);

        // Held redirect: no fetch while it stays high
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h0000_0100, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 32'd0, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic        rv;
            logic [31:0] rpc;
            rv  = ($urandom_range(0, 15) == 0);
            rpc = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 32'h60));
            cycle(rv, rpc, $urandom_range(0, 3) != 0);
        end

        // Reset mid-stream with a full buffer
        bad_en = 1'b0;
        cycle(1'b1, 32'h0000_0200, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'd0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_out_pc", out_pc, 32'd0);
        check("midrst_imem_addr", imem_addr, RESET_PC);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 6; i++) cycle(1'b0, 32'd0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
